// File: rtl/sys_defs.sv
// Shared writeback definitions: register file geometry, request/write-port packets
// and a small index helper used by the writeback arbiter.
package sys_defs;

  localparam int PHYS_REG_SZ = 64;
  localparam int XLEN        = 32;
  localparam int TAG_W       = $clog2(PHYS_REG_SZ);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } WB_REQ_PACKET;

  // Field-for-field match with the register file write port.
  typedef struct packed {
    logic             write_en;
    logic [TAG_W-1:0] write_tag;
    logic [XLEN-1:0]  write_data;
  } WB_PRF_PACKET;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr
// (wrapping) wins; produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Register file writeback arbiter: one holding slot per functional unit, drained
// round-robin into a registered write packet. Build option PRF_WB_ARB_REQ0_PRIORITY_EN
// gives requester 0 (load unit) absolute priority over the others.
module prf_wb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PHYS_REG_SZ = sys_defs::PHYS_REG_SZ,
  parameter int XLEN        = sys_defs::XLEN,
  parameter int TAG_W       = $clog2(PHYS_REG_SZ)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             wb_valid,
  output logic [TAG_W-1:0]                 wb_tag,
  output logic [XLEN-1:0]                  wb_data,
  output logic                             busy
);

  import sys_defs::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] occ;
  logic [TAG_W-1:0]   slot_tag_p0  [NUM_REQ];
  logic [XLEN-1:0]    slot_data_p0 [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] arb_req, arb_grant, grant, accept;
  logic [IDX_W-1:0]   arb_idx, grant_idx;
  logic               arb_any, grant_any, adv_ptr;

  logic               vld_p1;
  logic [TAG_W-1:0]   wb_tag_p1;
  logic [XLEN-1:0]    wb_data_p1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

`ifdef PRF_WB_ARB_REQ0_PRIORITY_EN
  // Requester 0 pre-empts the rotation, which then runs only over 1..NUM_REQ-1.
  assign arb_req = occ & ~NUM_REQ'(1);

  always_comb begin
    grant     = arb_grant;
    grant_idx = arb_idx;
    grant_any = arb_any;
    adv_ptr   = arb_any;
    if (occ[0]) begin
      grant     = NUM_REQ'(1);
      grant_idx = '0;
      grant_any = 1'b1;
      adv_ptr   = 1'b0;
    end
  end
`else
  assign arb_req   = occ;
  assign grant     = arb_grant;
  assign grant_idx = arb_idx;
  assign grant_any = arb_any;
  assign adv_ptr   = arb_any;
`endif

  // A slot being drained this cycle can take a new result at the same edge.
  assign req_ready = (reset || squash) ? '0 : (~occ | grant);
  assign accept    = req_valid & req_ready;
  assign busy      = |occ;

  // Stage p0: holding slots
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_tag_p0[i]  <= req_tag[i];
        slot_data_p0[i] <= req_data[i];
      end
    end
  end

  // Stage p1: write packet register
  always_ff @(posedge clock) begin
    if (reset) begin
      occ        <= '0;
      rr_ptr     <= '0;
      vld_p1     <= 1'b0;
      wb_tag_p1  <= '0;
      wb_data_p1 <= '0;
    end else if (squash) begin
      occ    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      occ    <= (occ & ~grant) | accept;
      vld_p1 <= grant_any;
      if (grant_any) begin
        wb_tag_p1  <= slot_tag_p0[grant_idx];
        wb_data_p1 <= slot_data_p0[grant_idx];
      end
      if (adv_ptr) rr_ptr <= IDX_W'(wrap_inc(32'(grant_idx), NUM_REQ));
    end
  end

  assign wb_valid = vld_p1;
  assign wb_tag   = wb_tag_p1;
  assign wb_data  = wb_data_p1;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: expected write packets are queued as stimulus
// is applied and popped whenever the DUT presents wb_valid.
module tb_prf_wb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int XLEN    = 32;

  logic clock = 1'b0;
  logic reset, squash;
  logic [NUM_REQ-1:0]            req_valid, req_ready;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_data;
  logic                          wb_valid, busy;
  logic [TAG_W-1:0]              wb_tag;
  logic [XLEN-1:0]               wb_data;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  prf_wb_arbiter #(.NUM_REQ(NUM_REQ), .PHYS_REG_SZ(64), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    exp_t e;
    e.tag  = t;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one edge, then score any write packet against the queue head.
  task automatic cyc();
    exp_t e;
    @(posedge clock);
    #1;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 64'(wb_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("wb_tag", 64'(wb_tag), 64'(e.tag));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic drive(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    req_valid[i] = 1'b1;
    req_tag[i]   = t;
    req_data[i]  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TAG_W-1:0] t;
    int               idx;

    reset = 1'b1; squash = 1'b0;
    req_valid = '0; req_tag = '0; req_data = '0;

    // Reset state
    cyc(); cyc();
    chk("ready_in_reset", 64'(req_ready), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_tag", 64'(wb_tag), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'(4'hF));

    // Single requester: two-edge latency
    drive(1, TAG_W'(5), 32'hDEADBEEF);
    push(TAG_W'(5), 32'hDEADBEEF);
    cyc(); idle();
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_early", 64'(wb_valid), 64'(0));
    cyc();
    chk("t1_wb_valid", 64'(wb_valid), 64'(1));
    chk("t1_busy_clr", 64'(busy), 64'(0));
    cyc();
    chk("t1_wb_drop", 64'(wb_valid), 64'(0));

    // Full contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) drive(i, TAG_W'(10 + i), 32'hC0DE0000 + 32'(i));
    for (int k = 2; k <= 13; k++) begin
`ifdef PRF_WB_ARB_REQ0_PRIORITY_EN
      idx = (k <= 10) ? 0 : k - 10;
`else
      idx = (k - 2) % 4;
`endif
      push(TAG_W'(10 + idx), 32'hC0DE0000 + 32'(idx));
    end
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k >= 2) chk("t2_wb_valid", 64'(wb_valid), 64'(1));
`ifdef PRF_WB_ARB_REQ0_PRIORITY_EN
      if (k <= 9) chk("t2_ready", 64'(req_ready), 64'(4'b0001));
`else
      if (k <= 9) chk("t2_ready", 64'(req_ready), 64'(4'b0001 << ((k - 1) % 4)));
`endif
      if (k == 9) idle();
    end
    cyc();
    chk("t2_wb_idle", 64'(wb_valid), 64'(0));
    chk("t2_busy", 64'(busy), 64'(0));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));

    // Refill: one requester streaming back to back
    for (int k = 0; k < 3; k++) begin
      t = TAG_W'(20 + k);
      drive(2, t, 32'h2000 + 32'(k));
      push(t, 32'h2000 + 32'(k));
      cyc();
      chk("t3_ready2", 64'(req_ready[2]), 64'(1));
      if (k >= 1) chk("t3_wb_valid", 64'(wb_valid), 64'(1));
    end
    idle();
    cyc();
    chk("t3_wb_last", 64'(wb_valid), 64'(1));
    cyc();
    chk("t3_wb_idle", 64'(wb_valid), 64'(0));
    chk("t3_sb_empty", 64'(sb.size()), 64'(0));

    // Squash discards buffered results and blocks new ones
    drive(0, TAG_W'(50), 32'h5000);
    drive(3, TAG_W'(53), 32'h5003);
    cyc(); idle();
    squash = 1'b1;
    drive(1, TAG_W'(51), 32'h5001);
    #1;
    chk("t4_ready_squash", 64'(req_ready), 64'(0));
    chk("t4_busy_before", 64'(busy), 64'(1));
    cyc();
    squash = 1'b0; idle();
    chk("t4_wb_valid", 64'(wb_valid), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));
    cyc(); cyc();
    chk("t4_wb_later", 64'(wb_valid), 64'(0));
    chk("t4_busy_later", 64'(busy), 64'(0));

    // Requesters 0 and 1 contending
    do_reset();
    drive(0, TAG_W'(30), 32'h300);
    drive(1, TAG_W'(31), 32'h301);
    for (int j = 0; j < 7; j++) begin
`ifdef PRF_WB_ARB_REQ0_PRIORITY_EN
      idx = (j < 6) ? 0 : 1;
`else
      idx = j % 2;
`endif
      push(TAG_W'(30 + idx), 32'h300 + 32'(idx));
    end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k >= 2) chk("t5_wb_valid", 64'(wb_valid), 64'(1));
      if (k == 6) idle();
    end
    cyc();
    chk("t5_wb_idle", 64'(wb_valid), 64'(0));
    chk("t5_sb_empty", 64'(sb.size()), 64'(0));

    // Reset mid-stream drops everything
    do_reset();
    for (int i = 0; i < 3; i++) drive(i, TAG_W'(40 + i), 32'h4000 + 32'(i));
    push(TAG_W'(40), 32'h4000);
    cyc(); cyc();
    chk("t6_wb_valid", 64'(wb_valid), 64'(1));
    chk("t6_busy", 64'(busy), 64'(1));
    reset = 1'b1; idle();
    cyc();
    chk("t6_rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("t6_rst_wb_tag", 64'(wb_tag), 64'(0));
    chk("t6_rst_wb_data", 64'(wb_data), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    cyc(); cyc();
    chk("t6_wb_after", 64'(wb_valid), 64'(0));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prf_wb_arbiter.md
Name: prf_wb_arbiter

Overview:
Shares the physical register file's single write port among NUM_REQ functional-unit result streams.
- Each requester deposits its result into a private one-entry holding slot via a valid/ready handshake.
- A round-robin arbiter drains one occupied slot per cycle into a registered write packet.
- That packet drives the register file write port and the completion broadcast to issue/retire logic.
- Sits between the execute-stage units and the register file.

Parameters:
NUM_REQ, 4, number of requesting functional units (2..8)
PHYS_REG_SZ, 64, number of physical registers
XLEN, 32, data width
TAG_W, $clog2(PHYS_REG_SZ), physical tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  pipeline flush; discards all buffered and pending results
req_valid  in  NUM_REQ  requester i presents a result
req_tag  in  NUM_REQ x TAG_W  destination physical register per requester
req_data  in  NUM_REQ x XLEN  result value per requester
req_ready  out  NUM_REQ  requester i's result is accepted this cycle when valid&ready
wb_valid  out  1  write packet valid (register file write enable)
wb_tag  out  TAG_W  write packet destination tag
wb_data  out  XLEN  write packet data
busy  out  1  at least one slot occupied

Behaviour:
- Slot per requester: occupied bit, tag, data.
  - Accept (valid & ready) loads the slot at the clock edge.
  - req_ready[i] = !occ[i] | grant[i], so a granted slot refills in the same cycle (full throughput of 1 result/cycle per requester when uncontended).
  - req_ready does not depend on req_valid (no combinational loop).
- Arbitration: combinational grant over occupied slots.
  - Round-robin starting at pointer rr_ptr.
  - At most one grant per cycle.
  - On grant of slot g, rr_ptr <= (g+1) mod NUM_REQ; no grant leaves rr_ptr unchanged.
- Output register: on grant, next edge sets wb_valid=1, wb_tag=slot tag, wb_data=slot data, and clears occ[g] unless refilled.
  - With no grant, wb_valid=0; tag/data hold last value.
  - Latency: accept at edge N, earliest write packet valid after edge N+1 (one cycle in slot, one in output register).
- Tag 0: slot accepted and granted normally. The write packet is issued with wb_valid=1 and the register file ignores the write.
- squash: at the next edge all occ cleared, wb_valid=0, rr_ptr kept.
  - Inputs presented in the squash cycle are not accepted.
  - req_ready is forced to 0 while squash=1.
- reset: occ=0, rr_ptr=0, wb_valid=0, wb_tag=0, wb_data=0.
  - req_ready is 0 during reset and all 1 in the first cycle after.
  - Reset mid-operation drops all buffered results.
- busy = |occ.
- Boundary cases:
  - All slots occupied: each granted in rotation, so every slot drains within NUM_REQ cycles.
  - Single occupied slot: granted immediately regardless of rr_ptr.

Optional Feature:
Macro PRF_WB_ARB_REQ0_PRIORITY_EN.
- Defined: requester 0 (load unit) has absolute priority whenever occ[0]. rr_ptr advances only on grants to requesters 1..NUM_REQ-1, and round-robin runs among those.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Shared package (sys_defs): PHYS_REG_SZ, XLEN, a WB_REQ_PACKET typedef (valid, tag, data) and a WB_PRF_PACKET typedef (write_en, write_tag, write_data). The latter maps directly onto the register file write-port packet.
- One sub-module: rr_arbiter (parameterised NUM_REQ; inputs request vector and pointer; outputs one-hot grant and index). Instantiated once.

Test Plan:
- Single requester: reset, then req_valid[1]=1, tag=5, data=0xDEADBEEF for one cycle -> wb_valid=1, wb_tag=5, wb_data=0xDEADBEEF exactly two edges later, then wb_valid=0; busy 1 for one cycle.
- Full contention: all 4 requesters valid continuously with tags 10..13, rr_ptr=0 -> wb_tag sequence 10,11,12,13,10,...; each req_ready pulses once per 4 cycles; wb_valid never drops.
- Refill: requester 2 streams tags 20,21,22 on consecutive cycles, others idle -> req_ready[2] stays 1; wb_tag 20,21,22 on consecutive cycles.
- Squash: slots 0 and 3 occupied, squash=1 -> next cycle busy=0, wb_valid=0, req_ready=0 during squash. Neither result is ever written.
- Priority macro defined: requester 0 valid every cycle, requester 1 valid -> requester 1 never granted until requester 0 idles, then granted next cycle. Macro undefined: alternating grants 0,1,0,1.
- Reset mid-stream: reset asserted with 3 occupied slots and wb_valid=1 -> next cycle wb_valid=0, wb_tag=0, wb_data=0, busy=0.
